// File: rtl/cub_mailbox_regfile_pkg.sv
// Shared types and constants for the CUB register file / mailbox block.
// Package name: cub_rf_pkg.
package cub_rf_pkg;

  localparam int NUM_REGS  = 32;
  localparam int R_MBX     = 17;
  localparam int R_ALL1    = 18;
  localparam int R_MSB     = 19;
  localparam int R_MAXPOS  = 20;
  localparam int R_NB_BASE = 21;
  localparam int NUM_NB    = 10;
  localparam int R_ID      = 31;

  localparam logic [31:0] C_ALL1   = 32'hFFFF_FFFF;
  localparam logic [31:0] C_MSB    = 32'h8000_0000;
  localparam logic [31:0] C_MAXPOS = 32'h7FFF_FFFF;

  typedef struct packed {
    logic [15:0] mult_lambda;
    logic [3:0]  mult_q;
    logic [31:0] arith_bias;
    logic [4:0]  arith_trunc_q;
    logic [4:0]  arith_elt_q;
    logic [15:0] prelu_scale;
    logic [4:0]  prelu_qp;
    logic [31:0] relu6_bias;
    logic [31:0] relu6_max;
    logic [31:0] relu6_min;
  } cub_alu_param_t;

  // A group select bit of 1 picks the even register of the pair.
  function automatic logic [31:0] pick(input logic sel, input logic [31:0] odd_v,
                                       input logic [31:0] even_v);
    return sel ? even_v : odd_v;
  endfunction

endpackage

// File: rtl/cub_mailbox_regfile_if.sv
// Mailbox (outbound) and rx (inbound) handshake bundle for cub_mailbox_regfile.
interface cub_mailbox_regfile_if #(
  parameter int MBX_DEPTH = 4
);
  logic [31:0]                  mbx_data_o;
  logic                         mbx_valid_o;
  logic                         mbx_ready_i;
  logic [31:0]                  rx_data_i;
  logic                         rx_valid_i;
  logic                         rx_ready_o;
  logic [$clog2(MBX_DEPTH):0]   mbx_count_o;
  logic                         mbx_ovf_o;

  modport slave (
    output mbx_data_o, mbx_valid_o, rx_ready_o, mbx_count_o, mbx_ovf_o,
    input  mbx_ready_i, rx_data_i, rx_valid_i
  );

  modport master (
    input  mbx_data_o, mbx_valid_o, rx_ready_o, mbx_count_o, mbx_ovf_o,
    output mbx_ready_i, rx_data_i, rx_valid_i
  );
endinterface

// File: rtl/cub_mailbox_regfile_mbx_fifo.sv
// Outbound mailbox FIFO: wrapping pointers with one extra bit, sticky overflow.
module cub_mbx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop_ready,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       ovf_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             full, empty, pop, accept;

  assign count_o = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (count_o == (AW+1)'(DEPTH));
  assign pop     = !empty && pop_ready;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign accept  = push && (!full || pop);
  assign valid_o = !empty;
  assign data_o  = mem[rptr[AW-1:0]];

  // Storage write; contents are meaningless while the pointers say empty.
  always_ff @(posedge clk) begin
    if (accept) mem[wptr[AW-1:0]] <= push_data;
  end

  // Pointer and overflow flag update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      ovf_o <= 1'b0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (push && !accept) ovf_o <= 1'b1;
    end
  end
endmodule

// File: rtl/cub_mailbox_regfile.sv
// CUB register file with constant/neighbour/id registers, ALU parameter
// selection and an R17 mailbox (outbound FIFO + inbound rx load).
// Optional macro CUB_RF_BYPASS_EN: reads of R1..R17 see same-cycle writes.
module cub_mailbox_regfile
  import cub_rf_pkg::*;
#(
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int DATA_WIDTH = 32,
  parameter int MBX_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            raddr_i [NUM_RD],
  output logic [DATA_WIDTH-1:0] rdata_o [NUM_RD],
  input  logic [4:0]            waddr_i [NUM_WR],
  input  logic [DATA_WIDTH-1:0] wdata_i [NUM_WR],
  input  logic [NUM_WR-1:0]     we_i,
  input  logic [4:0]            cub_id_i,
  input  logic [31:0]           nb_data_i [NUM_NB],
  input  logic [2:0]            param_sel_i,
  output cub_alu_param_t        param_o,
  cub_mailbox_regfile_if.slave  mbx_if
);

  logic [DATA_WIDTH-1:0] regs    [1:R_MBX];
  logic                  wr_hit  [1:R_MBX];
  logic [DATA_WIDTH-1:0] wr_data [1:R_MBX];
  logic [DATA_WIDTH-1:0] cur_val [NUM_REGS];
  logic                  rx_load;

  // Per-register winning write; later (higher-index) ports override earlier ones.
  always_comb begin
    for (int r = 1; r <= R_MBX; r++) begin
      wr_hit[r]  = 1'b0;
      wr_data[r] = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        if (we_i[p] && (waddr_i[p] == 5'(r))) begin
          wr_hit[r]  = 1'b1;
          wr_data[r] = wdata_i[p];
        end
      end
    end
  end

  assign mbx_if.rx_ready_o = !wr_hit[R_MBX];
  assign rx_load           = mbx_if.rx_valid_i && !wr_hit[R_MBX];

  // Writable register state; R17 takes port writes first, then rx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r <= R_MBX; r++) regs[r] <= '0;
    end else begin
      for (int r = 1; r < R_MBX; r++) begin
        if (wr_hit[r]) regs[r] <= wr_data[r];
      end
      if (wr_hit[R_MBX]) regs[R_MBX] <= wr_data[R_MBX];
      else if (rx_load)  regs[R_MBX] <= DATA_WIDTH'(mbx_if.rx_data_i);
    end
  end

  // Full 32-entry read view, optionally forwarding same-cycle writes.
  always_comb begin
    cur_val[0] = '0;
    for (int r = 1; r <= R_MBX; r++) begin
      cur_val[r] = regs[r];
`ifdef CUB_RF_BYPASS_EN
      if (wr_hit[r]) cur_val[r] = wr_data[r];
`endif
    end
`ifdef CUB_RF_BYPASS_EN
    if (rx_load) cur_val[R_MBX] = DATA_WIDTH'(mbx_if.rx_data_i);
`endif
    cur_val[R_ALL1]   = DATA_WIDTH'(C_ALL1);
    cur_val[R_MSB]    = DATA_WIDTH'(C_MSB);
    cur_val[R_MAXPOS] = DATA_WIDTH'(C_MAXPOS);
    for (int i = 0; i < NUM_NB; i++) cur_val[R_NB_BASE+i] = DATA_WIDTH'(nb_data_i[i]);
    cur_val[R_ID] = DATA_WIDTH'({27'b0, cub_id_i});
  end

  // Combinational read ports.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) rdata_o[p] = cur_val[raddr_i[p]];
  end

  // ALU parameter selection from the registered parameter bank.
  always_comb begin
    param_o               = '0;
    param_o.mult_lambda   = 16'(pick(param_sel_i[0], 32'(regs[1]), 32'(regs[2])));
    param_o.mult_q        = 4'(pick(param_sel_i[0], 32'(regs[1]), 32'(regs[2])) >> 16);
    param_o.arith_bias    = pick(param_sel_i[1], 32'(regs[3]), 32'(regs[4]));
    param_o.arith_trunc_q = 5'(pick(param_sel_i[1], 32'(regs[5]), 32'(regs[6])));
    param_o.arith_elt_q   = 5'(pick(param_sel_i[1], 32'(regs[15]), 32'(regs[16])));
    param_o.prelu_scale   = 16'(pick(param_sel_i[2], 32'(regs[7]), 32'(regs[8])));
    param_o.prelu_qp      = 5'(pick(param_sel_i[2], 32'(regs[7]), 32'(regs[8])) >> 16);
    param_o.relu6_bias    = pick(param_sel_i[2], 32'(regs[9]), 32'(regs[10]));
    param_o.relu6_max     = pick(param_sel_i[2], 32'(regs[11]), 32'(regs[12]));
    param_o.relu6_min     = pick(param_sel_i[2], 32'(regs[13]), 32'(regs[14]));
  end

  cub_mbx_fifo #(
    .DEPTH (MBX_DEPTH),
    .WIDTH (32)
  ) u_mbx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_hit[R_MBX]),
    .push_data (32'(wr_data[R_MBX])),
    .pop_ready (mbx_if.mbx_ready_i),
    .data_o    (mbx_if.mbx_data_o),
    .valid_o   (mbx_if.mbx_valid_o),
    .count_o   (mbx_if.mbx_count_o),
    .ovf_o     (mbx_if.mbx_ovf_o)
  );

endmodule

// File: tb/tb_cub_mailbox_regfile.sv
// Self-checking bench for cub_mailbox_regfile against a queue/array model.
module tb_cub_mailbox_regfile;
  import cub_rf_pkg::*;

  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int DW     = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [4:0]        raddr [NUM_RD];
  logic [DW-1:0]     rdata [NUM_RD];
  logic [4:0]        waddr [NUM_WR];
  logic [DW-1:0]     wdata [NUM_WR];
  logic [NUM_WR-1:0] we;
  logic [4:0]        cub_id;
  logic [31:0]       nb_data [10];
  logic [2:0]        param_sel;
  cub_alu_param_t    param;

  cub_mailbox_regfile_if #(.MBX_DEPTH(DEPTH)) mbx_if ();

  cub_mailbox_regfile #(
    .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .DATA_WIDTH(DW), .MBX_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .cub_id_i(cub_id),
    .nb_data_i(nb_data), .param_sel_i(param_sel), .param_o(param),
    .mbx_if(mbx_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_reg [1:17];
  logic [31:0] m_fifo [$];
  bit          m_ovf;

  function automatic void model_clear();
    for (int r = 1; r <= 17; r++) m_reg[r] = '0;
    m_fifo.delete();
    m_ovf = 0;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    logic [31:0] v;
    bit h;
    h = 0;
    if (a == 0) v = 0;
    else if (a <= 17) v = m_reg[a];
    else if (a == 18) v = 32'hFFFF_FFFF;
    else if (a == 19) v = 32'h8000_0000;
    else if (a == 20) v = 32'h7FFF_FFFF;
    else if (a <= 30) v = nb_data[a - 21];
    else v = {27'b0, cub_id};
`ifdef CUB_RF_BYPASS_EN
    if (a >= 1 && a <= 17) begin
      for (int p = 0; p < NUM_WR; p++)
        if (we[p] && waddr[p] == a) begin v = wdata[p]; h = 1; end
      if (a == 17 && !h && mbx_if.rx_valid_i) v = mbx_if.rx_data_i;
    end
`endif
    return v;
  endfunction

  function automatic logic exp_rx_ready();
    logic ok;
    ok = 1;
    for (int p = 0; p < NUM_WR; p++) if (we[p] && waddr[p] == 17) ok = 0;
    return ok;
  endfunction

  function automatic cub_alu_param_t exp_param();
    cub_alu_param_t e;
    logic [31:0] m, tq, eq, b, pr, rb, rx, rn;
    m  = param_sel[0] ? m_reg[2]  : m_reg[1];
    b  = param_sel[1] ? m_reg[4]  : m_reg[3];
    tq = param_sel[1] ? m_reg[6]  : m_reg[5];
    eq = param_sel[1] ? m_reg[16] : m_reg[15];
    pr = param_sel[2] ? m_reg[8]  : m_reg[7];
    rb = param_sel[2] ? m_reg[10] : m_reg[9];
    rx = param_sel[2] ? m_reg[12] : m_reg[11];
    rn = param_sel[2] ? m_reg[14] : m_reg[13];
    e.mult_lambda   = m[15:0];
    e.mult_q        = m[19:16];
    e.arith_bias    = b;
    e.arith_trunc_q = tq[4:0];
    e.arith_elt_q   = eq[4:0];
    e.prelu_scale   = pr[15:0];
    e.prelu_qp      = pr[20:16];
    e.relu6_bias    = rb;
    e.relu6_max     = rx;
    e.relu6_min     = rn;
    return e;
  endfunction

  task automatic drive_idle();
    for (int p = 0; p < NUM_WR; p++) begin waddr[p] = 0; wdata[p] = 0; end
    we = '0;
    mbx_if.mbx_ready_i = 0;
    mbx_if.rx_valid_i  = 0;
    mbx_if.rx_data_i   = 0;
  endtask

  // Advance one clock edge and update the model from the inputs driven now.
  task automatic cycle();
    bit          hit [1:17];
    logic [31:0] hd  [1:17];
    bit          pop, rxl;
    logic [31:0] rxd;
    for (int r = 1; r <= 17; r++) begin hit[r] = 0; hd[r] = 0; end
    for (int p = 0; p < NUM_WR; p++)
      if (we[p] && waddr[p] >= 1 && waddr[p] <= 17) begin
        hit[waddr[p]] = 1;
        hd[waddr[p]]  = wdata[p];
      end
    pop = (m_fifo.size() > 0) && mbx_if.mbx_ready_i;
    rxl = mbx_if.rx_valid_i && !hit[17];
    rxd = mbx_if.rx_data_i;
    @(posedge clk);
    #1;
    if (pop) void'(m_fifo.pop_front());
    if (hit[17]) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(hd[17]);
      else m_ovf = 1;
    end
    for (int r = 1; r <= 17; r++) if (hit[r]) m_reg[r] = hd[r];
    if (rxl) m_reg[17] = rxd;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 0;
    model_clear();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 0;
    raddr[0] = 1; raddr[1] = 17; param_sel = 3'b101;
    #1;
    model_clear();
    checks++; if (mbx_if.mbx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", mbx_if.mbx_valid_o); end
    checks++; if (mbx_if.mbx_count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", mbx_if.mbx_count_o); end
    checks++; if (mbx_if.mbx_ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", mbx_if.mbx_ovf_o); end
    checks++; if (param !== '0) begin errors++; $display("FAIL reset_param got %h exp 0", param); end
    checks++; if (rdata[0] !== 32'h0 || rdata[1] !== 32'h0) begin errors++; $display("FAIL reset_regs got %h/%h exp 0/0", rdata[0], rdata[1]); end
    checks++; if (mbx_if.rx_ready_o !== 1'b1) begin errors++; $display("FAIL reset_rx_ready got %b exp 1", mbx_if.rx_ready_o); end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_priority();
    drive_idle();
    we = 2'b11; waddr[0] = 5; wdata[0] = 32'h1F; waddr[1] = 5; wdata[1] = 32'h03;
    cycle();
    drive_idle();
    raddr[0] = 5; param_sel = 3'b000;
    #1;
    checks++; if (rdata[0] !== 32'h03) begin errors++; $display("FAIL prio_r5 got %h exp 00000003", rdata[0]); end
    checks++; if (param.arith_trunc_q !== 5'd3) begin errors++; $display("FAIL prio_trunc_q got %0d exp 3", param.arith_trunc_q); end
  endtask

  task automatic test_readonly();
    drive_idle();
    cub_id = 5'(($urandom % 31) + 1);
    for (int i = 0; i < 10; i++) nb_data[i] = $urandom;
    we = 2'b11; waddr[0] = 0; wdata[0] = 32'h1234; waddr[1] = 20; wdata[1] = 0;
    cycle();
    drive_idle();
    raddr[0] = 0; raddr[1] = 20;
    #1;
    checks++; if (rdata[0] !== 32'h0) begin errors++; $display("FAIL ro_r0 got %h exp 0", rdata[0]); end
    checks++; if (rdata[1] !== 32'h7FFF_FFFF) begin errors++; $display("FAIL ro_r20 got %h exp 7fffffff", rdata[1]); end
    raddr[0] = 31; raddr[1] = 21;
    #1;
    checks++; if (rdata[0] !== {27'b0, cub_id}) begin errors++; $display("FAIL ro_r31 got %h exp %h", rdata[0], {27'b0, cub_id}); end
    checks++; if (rdata[1] !== nb_data[0]) begin errors++; $display("FAIL ro_r21 got %h exp %h", rdata[1], nb_data[0]); end
  endtask

  task automatic test_bypass();
    logic [31:0] old, exp_same;
    drive_idle();
    we = 2'b01; waddr[0] = 9; wdata[0] = 32'h1234_5678;
    cycle();
    old = 32'h1234_5678;
`ifdef CUB_RF_BYPASS_EN
    exp_same = 32'd7;
`else
    exp_same = old;
`endif
    drive_idle();
    we = 2'b01; waddr[0] = 9; wdata[0] = 32'd7; raddr[0] = 9;
    #1;
    checks++; if (rdata[0] !== exp_same) begin errors++; $display("FAIL bypass_same got %h exp %h", rdata[0], exp_same); end
    cycle();
    we = '0;
    #1;
    checks++; if (rdata[0] !== 32'd7) begin errors++; $display("FAIL bypass_next got %h exp 7", rdata[0]); end
  endtask

  task automatic test_rx_collision();
    do_reset();
    mbx_if.rx_valid_i = 1; mbx_if.rx_data_i = 32'hAA;
    we = 2'b01; waddr[0] = 17; wdata[0] = 32'h55; raddr[0] = 17;
    #1;
    checks++; if (mbx_if.rx_ready_o !== 1'b0) begin errors++; $display("FAIL rx_ready_blocked got %b exp 0", mbx_if.rx_ready_o); end
    cycle();
    we = '0;
    #1;
    checks++; if (rdata[0] !== 32'h55 || mbx_if.mbx_count_o !== 3'd1) begin
      errors++; $display("FAIL rx_port_wins got r17=%h cnt=%0d exp 55/1", rdata[0], mbx_if.mbx_count_o); end
    checks++; if (mbx_if.rx_ready_o !== 1'b1) begin errors++; $display("FAIL rx_ready_free got %b exp 1", mbx_if.rx_ready_o); end
    cycle();
    drive_idle();
    #1;
    checks++; if (rdata[0] !== 32'hAA || mbx_if.mbx_count_o !== 3'd1) begin
      errors++; $display("FAIL rx_load got r17=%h cnt=%0d exp aa/1", rdata[0], mbx_if.mbx_count_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    raddr[0] = 17;
    for (int k = 0; k < 5; k++) begin
      we = 2'b01; waddr[0] = 17; wdata[0] = 32'h101 + k;
      cycle();
    end
    we = '0;
    #1;
    checks++; if (mbx_if.mbx_count_o !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d exp 4", mbx_if.mbx_count_o); end
    checks++; if (mbx_if.mbx_ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", mbx_if.mbx_ovf_o); end
    checks++; if (rdata[0] !== 32'h105) begin errors++; $display("FAIL ovf_r17 got %h exp 105", rdata[0]); end
    mbx_if.mbx_ready_i = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (mbx_if.mbx_valid_o !== 1'b1 || mbx_if.mbx_data_o !== 32'h101 + k) begin
        errors++; $display("FAIL ovf_pop%0d got v=%b d=%h exp 1/%h", k, mbx_if.mbx_valid_o, mbx_if.mbx_data_o, 32'h101 + k); end
      cycle();
    end
    checks++; if (mbx_if.mbx_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b exp 0", mbx_if.mbx_valid_o); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      we = 2'b10; waddr[1] = 17; wdata[1] = 32'h201 + k;
      cycle();
    end
    wdata[1] = 32'h205; mbx_if.mbx_ready_i = 1;
    #1;
    checks++; if (mbx_if.mbx_data_o !== 32'h201) begin errors++; $display("FAIL full_head got %h exp 201", mbx_if.mbx_data_o); end
    cycle();
    we = '0;
    #1;
    checks++; if (mbx_if.mbx_count_o !== 3'd4 || mbx_if.mbx_ovf_o !== 1'b0) begin
      errors++; $display("FAIL full_pushpop got cnt=%0d ovf=%b exp 4/0", mbx_if.mbx_count_o, mbx_if.mbx_ovf_o); end
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (mbx_if.mbx_data_o !== 32'h202 + k) begin
        errors++; $display("FAIL full_order%0d got %h exp %h", k, mbx_if.mbx_data_o, 32'h202 + k); end
      cycle();
    end
  endtask

  task automatic test_empty_push_pop();
    do_reset();
    we = 2'b01; waddr[0] = 17; wdata[0] = 32'h301; mbx_if.mbx_ready_i = 1;
    #1;
    checks++; if (mbx_if.mbx_valid_o !== 1'b0) begin errors++; $display("FAIL empty_valid got %b exp 0", mbx_if.mbx_valid_o); end
    cycle();
    we = '0; mbx_if.mbx_ready_i = 0;
    #1;
    checks++; if (mbx_if.mbx_valid_o !== 1'b1 || mbx_if.mbx_data_o !== 32'h301) begin
      errors++; $display("FAIL empty_next got v=%b d=%h exp 1/301", mbx_if.mbx_valid_o, mbx_if.mbx_data_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      we = 2'b01; waddr[0] = 17; wdata[0] = $urandom;
      cycle();
    end
    drive_idle();
    rst_n = 0;
    #1;
    model_clear();
    checks++; if (mbx_if.mbx_valid_o !== 1'b0 || mbx_if.mbx_count_o !== 3'd0) begin
      errors++; $display("FAIL midrst_async got v=%b cnt=%0d exp 0/0", mbx_if.mbx_valid_o, mbx_if.mbx_count_o); end
    @(negedge clk);
    rst_n = 1;
    mbx_if.mbx_ready_i = 1;
    cycle();
    checks++; if (mbx_if.mbx_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_after got v=%b exp 0", mbx_if.mbx_valid_o); end
  endtask

  task automatic test_random();
    logic [4:0] same;
    do_reset();
    for (int it = 0; it < 400; it++) begin
      same = 5'(($urandom % 17) + 1);
      for (int p = 0; p < NUM_WR; p++) begin
        we[p]    = ($urandom % 2) == 0;
        waddr[p] = ($urandom % 10 < 7) ? 5'(($urandom % 17) + 1) : 5'($urandom);
        if ($urandom % 10 < 2) waddr[p] = 17;
        wdata[p] = $urandom;
      end
      if ($urandom % 4 == 0) begin waddr[0] = same; waddr[1] = same; end
      for (int p = 0; p < NUM_RD; p++) raddr[p] = 5'($urandom);
      mbx_if.mbx_ready_i = ($urandom % 10) < 4;
      mbx_if.rx_valid_i  = ($urandom % 10) < 3;
      mbx_if.rx_data_i   = $urandom;
      param_sel = 3'($urandom);
      if ($urandom % 8 == 0) nb_data[$urandom % 10] = $urandom;
      if ($urandom % 16 == 0) cub_id = 5'($urandom);
      #1;
      for (int p = 0; p < NUM_RD; p++) begin
        checks++; if (rdata[p] !== exp_rd(raddr[p])) begin
          errors++; $display("FAIL rnd_rd%0d it=%0d addr=%0d got %h exp %h", p, it, raddr[p], rdata[p], exp_rd(raddr[p])); end
      end
      checks++; if (mbx_if.rx_ready_o !== exp_rx_ready()) begin
        errors++; $display("FAIL rnd_rx_ready it=%0d got %b exp %b", it, mbx_if.rx_ready_o, exp_rx_ready()); end
      checks++; if (mbx_if.mbx_count_o !== 3'(m_fifo.size()) || mbx_if.mbx_valid_o !== (m_fifo.size() > 0)) begin
        errors++; $display("FAIL rnd_occ it=%0d got cnt=%0d v=%b exp %0d", it, mbx_if.mbx_count_o, mbx_if.mbx_valid_o, m_fifo.size()); end
      if (m_fifo.size() > 0) begin
        checks++; if (mbx_if.mbx_data_o !== m_fifo[0]) begin
          errors++; $display("FAIL rnd_head it=%0d got %h exp %h", it, mbx_if.mbx_data_o, m_fifo[0]); end
      end
      checks++; if (mbx_if.mbx_ovf_o !== m_ovf) begin
        errors++; $display("FAIL rnd_ovf it=%0d got %b exp %b", it, mbx_if.mbx_ovf_o, m_ovf); end
      checks++; if (param !== exp_param()) begin
        errors++; $display("FAIL rnd_param it=%0d got %h exp %h", it, param, exp_param()); end
      cycle();
    end
  endtask

  initial begin
    cub_id = 5'd9;
    for (int i = 0; i < 10; i++) nb_data[i] = 32'h0;
    for (int p = 0; p < NUM_RD; p++) raddr[p] = 0;
    param_sel = 0;
    drive_idle();
    rst_n = 0;
    #2;
    test_reset();
    test_priority();
    test_readonly();
    test_bypass();
    test_rx_collision();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
